serial_ripple_borrow_subtractor: RTL and testbench

- Bit-serial subtractor: diff = a - b - bin (mod 2^N), with borrow-out and signed-overflow flags.
- Processes one bit per clock, LSB first, through a single borrow flip-flop. It is the sequential, area-minimal subtract counterpart of the team's parallel ripple adders.
- Sits in the arithmetic datapath behind a valid/ready handshake on both operand and result sides.

---
 rtl/serial_ripple_borrow_subtractor_if.sv | 26 ++
 rtl/serial_ripple_borrow_subtractor.sv | 103 ++++++++++
 tb/tb_serial_ripple_borrow_subtractor.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_ripple_borrow_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor; the master side feeds and drains it.
interface serial_ripple_borrow_subtractor_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial a - b - bin, LSB first through one borrow flop.
// Result, borrow-out and signed overflow are registered on the last bit.
module serial_ripple_borrow_subtractor #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    serial_ripple_borrow_subtractor_if.slave bus,
    output logic busy
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  res;
    logic [CW-1:0] cnt;
    logic          br;
    logic [N-1:0]  diff_q;
    logic          bout_q;
    logic          ovf_q;

    logic          d;
    logic          br_nxt;
    logic          last;
    logic [N-1:0]  res_nxt;

    assign d       = sa[0] ^ sb[0] ^ br;
    assign br_nxt  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last    = (cnt == CW'(N - 1));
    assign res_nxt = {d, res[N-1:1]};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        br  <= bus.bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nxt;
                    res <= res_nxt;
                    cnt <= cnt + CW'(1);
                    // On the MSB, br is the borrow in and br_nxt the borrow out.
                    if (last) begin
                        diff_q <= res_nxt;
                        bout_q <= br_nxt;
                        ovf_q  <= br ^ br_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign busy          = (state == RUN);
endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Directed N=4 vectors and corner sequences, plus a random N=8 stream
// with output stalls checked against an arithmetic reference.
module tb_serial_ripple_borrow_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy4;
    logic busy8;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    serial_ripple_borrow_subtractor_if #(.N(4)) if4 ();
    serial_ripple_borrow_subtractor_if #(.N(8)) if8 ();

    serial_ripple_borrow_subtractor #(.N(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if4.slave),
        .busy (busy4)
    );

    serial_ripple_borrow_subtractor #(.N(8)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if8.slave),
        .busy (busy8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic wait_ov4(output int lat);
        lat = 0;
        while (!if4.out_valid && lat < 50) begin
            step();
            lat++;
        end
        chk("ov4_timeout", 32'(if4.out_valid), 32'd1);
    endtask

    task automatic accept4(input logic [3:0] a, input logic [3:0] b,
                           input logic bin);
        if4.a        = a;
        if4.b        = b;
        if4.bin      = bin;
        if4.in_valid = 1'b1;
        step();
        if4.in_valid = 1'b0;
        if4.a        = ~a;
        if4.b        = ~b;
        if4.bin      = ~bin;
    endtask

    task automatic do4(input vec_t v);
        int lat;
        chk("rdy_pre", 32'(if4.in_ready), 32'd1);
        accept4(v.a, v.b, v.bin);
        chk("busy_run", 32'(busy4), 32'd1);
        wait_ov4(lat);
        // accept cycle plus N RUN cycles precede the first out_valid cycle
        chk("lat4", 32'(lat + 1), 32'd5);
        chk("diff4", 32'(if4.diff), 32'(v.d));
        chk("bout4", 32'(if4.bout), 32'(v.bo));
        chk("ovf4", 32'(if4.ovf), 32'(v.ov));
        if4.out_ready = 1'b1;
        step();
        if4.out_ready = 1'b0;
        chk("rdy_post", 32'(if4.in_ready), 32'd1);
        chk("ov_post", 32'(if4.out_valid), 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        int lat;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ebin;
        logic [8:0] full;
        int         s;
        logic       r;

        tbl[0] = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0, 1'b1};
        tbl[1] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0};
        tbl[2] = '{4'd7,  4'd7,  1'b0, 4'h0, 1'b0, 1'b0};
        tbl[3] = '{4'd8,  4'd1,  1'b0, 4'h7, 1'b0, 1'b1};
        tbl[4] = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[5] = '{4'd2,  4'd5,  1'b1, 4'hC, 1'b1, 1'b0};
        tbl[6] = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1, 1'b1};

        if4.in_valid  = 1'b0;
        if4.a         = '0;
        if4.b         = '0;
        if4.bin       = 1'b0;
        if4.out_ready = 1'b0;
        if8.in_valid  = 1'b0;
        if8.a         = '0;
        if8.b         = '0;
        if8.bin       = 1'b0;
        if8.out_ready = 1'b0;

        step();
        step();
        chk("rst_rdy", 32'(if4.in_ready), 32'd1);
        chk("rst_ov", 32'(if4.out_valid), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_diff", 32'(if4.diff), 32'd0);
        chk("rst_bout", 32'(if4.bout), 32'd0);
        chk("rst_ovf", 32'(if4.ovf), 32'd0);
        chk("rst_rdy8", 32'(if8.in_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do4(tbl[i]);
        end
        chk("persist_idle", 32'(if4.diff), 32'hA);

        // backpressure with ignored operand pulses
        accept4(4'd9, 4'd3, 1'b0);
        chk("persist_run", 32'(if4.diff), 32'hA);
        wait_ov4(lat);
        for (int k = 0; k < 5; k++) begin
            if4.in_valid = 1'b1;
            if4.a        = 4'd1;
            if4.b        = 4'd2;
            step();
            chk("bp_ov", 32'(if4.out_valid), 32'd1);
            chk("bp_rdy", 32'(if4.in_ready), 32'd0);
            chk("bp_diff", 32'(if4.diff), 32'h6);
            chk("bp_bout", 32'(if4.bout), 32'd0);
            chk("bp_ovf", 32'(if4.ovf), 32'd1);
        end
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        step();
        if4.out_ready = 1'b0;
        chk("bp_hs_ov", 32'(if4.out_valid), 32'd0);
        chk("bp_hs_rdy", 32'(if4.in_ready), 32'd1);

        // reset on the second RUN cycle
        accept4(4'd9, 4'd3, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_rdy", 32'(if4.in_ready), 32'd1);
        chk("mr_busy", 32'(busy4), 32'd0);
        chk("mr_ov", 32'(if4.out_valid), 32'd0);
        chk("mr_diff", 32'(if4.diff), 32'd0);
        chk("mr_ovf", 32'(if4.ovf), 32'd0);
        do4('{4'd7, 4'd2, 1'b0, 4'h5, 1'b0, 1'b0});

        // reset wins over a simultaneous operand
        rst          = 1'b1;
        if4.in_valid = 1'b1;
        if4.a        = 4'd5;
        step();
        rst          = 1'b0;
        if4.in_valid = 1'b0;
        step();
        chk("rv_busy", 32'(busy4), 32'd0);
        chk("rv_rdy", 32'(if4.in_ready), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            ea   = 8'($urandom);
            eb   = 8'($urandom);
            ebin = 1'($urandom);
            full = {1'b0, ea} - {1'b0, eb} - {8'd0, ebin};
            s    = int'($signed(ea)) - int'($signed(eb)) - int'(ebin);
            if8.a        = ea;
            if8.b        = eb;
            if8.bin      = ebin;
            if8.in_valid = 1'b1;
            lat = 0;
            while (!if8.in_ready && lat < 50) begin
                step();
                lat++;
            end
            step();
            if8.in_valid = 1'b0;
            if8.a        = 8'($urandom);
            if8.b        = 8'($urandom);
            lat = 0;
            while (!if8.out_valid && lat < 50) begin
                step();
                lat++;
            end
            chk("lat8", 32'(lat + 1), 32'd9);
            chk("diff8", 32'(if8.diff), 32'(full[7:0]));
            chk("bout8", 32'(if8.bout), 32'(full[8]));
            chk("ovf8", 32'(if8.ovf), 32'((s > 127) || (s < -128)));
            for (int k = 0; k < 40; k++) begin
                r = (k > 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
                if8.out_ready = r;
                step();
                if (r) break;
            end
            if8.out_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
